// File: rtl/sacred_power_sequencer.sv
// sacred_power_sequencer
//    Evaluates V = n * 3^k * pi^m * phi^p * e^q in 16.16 fixed point. Each unit
//    exponent step multiplies the accumulator by a constant (or its reciprocal
//    when the exponent is negative) on one shared pipelined multiplier.
//
// Ports
//    clk, reset           clock, synchronous active-high reset
//    in_valid/in_ready    request handshake (in_ready high only in IDLE)
//    n_in                 unsigned integer base
//    k_in/m_in/p_in/q_in  signed exponents of 3, pi, phi, e
//    out_valid/out_ready  result handshake; result held until accepted
//    sacred_value         unsigned 48.16 result (all-ones when saturated)
//    overflow             result saturated, qualified by out_valid
//    busy                 high in STEP, WAIT and DONE
//
// state | meaning
// IDLE  | waiting for a request; in_ready high
// STEP  | issue acc x constant for the first exponent with magnitude left
// WAIT  | wait MUL_LAT cycles for the product, then update acc
// DONE  | present result; leave on out_valid & out_ready

module sacred_power_sequencer #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] n_in,
   input  logic [7:0]  k_in,
   input  logic [7:0]  m_in,
   input  logic [7:0]  p_in,
   input  logic [7:0]  q_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] sacred_value,
   output logic        overflow,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0] WAIT_INIT = 2'(MUL_LAT - 1);

   state_t                    state_q, state_d;
   logic [63:0]               acc_q, acc_d;
   logic [3:0][7:0]           mag_q, mag_d;
   logic [3:0]                neg_q, neg_d;
   logic [1:0]                wait_q, wait_d;
   logic                      ovf_q, ovf_d;
   logic                      out_valid_q, out_valid_d;
   logic [63:0]               value_q, value_d;
   logic [MUL_LAT-1:0][95:0]  mul_pipe_q, mul_pipe_d;

   logic [1:0]  sel_idx;
   logic [31:0] const_sel;
   logic [95:0] mul_out;

   function automatic logic [7:0] mag_of(input logic [7:0] e);
      // -128 maps to magnitude 128, which still fits in 8 unsigned bits
      return e[7] ? 8'(-e) : e;
   endfunction

   function automatic logic [31:0] const_of(input logic [1:0] idx, input logic neg);
      logic [31:0] c;
      c = 32'd0;
      case (idx)
         2'd0: c = neg ? 32'h0000_5555 : 32'h0003_0000;
         2'd1: c = neg ? 32'h0000_517C : 32'h0003_243F;
         2'd2: c = neg ? 32'h0000_9E37 : 32'h0001_9E37;
         2'd3: c = neg ? 32'h0000_5E2D : 32'h0002_B7E1;
         default: c = 32'd0;
      endcase
      return c;
   endfunction

   // first nonzero magnitude in the order k, m, p, q
   always_comb begin
      sel_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mag_q[i] != 8'd0) sel_idx = 2'(i);
      end
      const_sel = const_of(sel_idx, neg_q[sel_idx]);
   end

   // the multiply lands in stage 0 at the STEP edge; later stages just delay it
   always_comb begin
      mul_pipe_d    = mul_pipe_q;
      mul_pipe_d[0] = (state_q == ST_STEP) ? (96'(acc_q) * 96'(const_sel)) : mul_pipe_q[0];
      for (int i = 1; i < MUL_LAT; i++) begin
         mul_pipe_d[i] = mul_pipe_q[i-1];
      end
   end

   assign mul_out = mul_pipe_q[MUL_LAT-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         mag_q       <= '0;
         neg_q       <= '0;
         wait_q      <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         value_q     <= '0;
         mul_pipe_q  <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mag_q       <= mag_d;
         neg_q       <= neg_d;
         wait_q      <= wait_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         value_q     <= value_d;
         mul_pipe_q  <= mul_pipe_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      mag_d       = mag_q;
      neg_d       = neg_q;
      wait_d      = wait_q;
      ovf_d       = ovf_q;
      out_valid_d = out_valid_q;
      value_d     = value_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               mag_d   = {mag_of(q_in), mag_of(p_in), mag_of(m_in), mag_of(k_in)};
               neg_d   = {q_in[7], p_in[7], m_in[7], k_in[7]};
               acc_d   = {16'd0, n_in, 16'd0};
               ovf_d   = 1'b0;
               state_d = (|{k_in, m_in, p_in, q_in}) ? ST_STEP : ST_DONE;
            end
         end
         ST_STEP: begin
            mag_d[sel_idx] = mag_q[sel_idx] - 8'd1;
            wait_d         = WAIT_INIT;
            state_d        = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_q == 2'd0) begin
               // P = product[95:16]; anything above P[63:0] means saturation
               if (mul_out[95:80] != 16'd0) begin
                  acc_d   = '1;
                  ovf_d   = 1'b1;
                  mag_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  acc_d   = mul_out[79:16];
                  state_d = (|mag_q) ? ST_STEP : ST_DONE;
               end
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_DONE: begin
            // one registering cycle before out_valid rises
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               value_d     = acc_q;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready     = (state_q == ST_IDLE);
      busy         = (state_q != ST_IDLE);
      out_valid    = out_valid_q;
      sacred_value = value_q;
      overflow     = ovf_q;
   end

endmodule

// File: tb/tb_sacred_power_sequencer.sv
module tb_sacred_power_sequencer;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] n_in;
   logic [7:0]  k_in, m_in, p_in, q_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] sacred_value;
   logic        overflow;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] cpos [4] = '{32'h0003_0000, 32'h0003_243F, 32'h0001_9E37, 32'h0002_B7E1};
   logic [31:0] cneg [4] = '{32'h0000_5555, 32'h0000_517C, 32'h0000_9E37, 32'h0000_5E2D};

   always #5 clk = ~clk;

   sacred_power_sequencer #(.MUL_LAT(LAT)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .n_in         (n_in),
      .k_in         (k_in),
      .m_in         (m_in),
      .p_in         (p_in),
      .q_in         (q_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .sacred_value (sacred_value),
      .overflow     (overflow),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: repeated exact multiply then floor-divide by 2^16, saturating
   // when the quotient no longer fits 64 bits.
   function automatic void model(input logic [31:0] n, input int e0, input int e1,
                                 input int e2, input int e3, output logic [63:0] val,
                                 output logic ovf, output int steps);
      int          ex [4];
      logic [95:0] prod;
      logic [31:0] c;
      int          cnt;
      ex    = '{e0, e1, e2, e3};
      val   = {16'd0, n, 16'd0};
      ovf   = 1'b0;
      steps = 0;
      for (int i = 0; i < 4; i++) begin
         c   = (ex[i] < 0) ? cneg[i] : cpos[i];
         cnt = (ex[i] < 0) ? -ex[i] : ex[i];
         for (int j = 0; j < cnt; j++) begin
            if (!ovf) begin
               steps++;
               prod = 96'(val) * 96'(c);
               prod = prod >> 16;
               if (prod[95:64] != 32'd0) begin
                  ovf = 1'b1;
                  val = '1;
               end else begin
                  val = prod[63:0];
               end
            end
         end
      end
   endfunction

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_req(input logic [31:0] n, input int k, input int m, input int p,
                          input int q, input int hold);
      logic [63:0] exp_val;
      logic        exp_ovf;
      int          steps;
      int          lat;
      logic        got;
      model(n, k, m, p, q, exp_val, exp_ovf, steps);
      @(negedge clk);
      check("in_ready_before_req", in_ready, 1'b1);
      n_in = n; k_in = 8'(k); m_in = 8'(m); p_in = 8'(p); q_in = 8'(q);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 4000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) got = 1'b1;
      end
      check("out_valid_timeout", got, 1'b1);
      if (!got) begin
         pulse_reset();
         return;
      end
      check("latency", 64'(lat), 64'(1 + steps * (LAT + 1)));
      check("sacred_value", sacred_value, exp_val);
      check("overflow", overflow, exp_ovf);
      check("busy_done", busy, 1'b1);
      check("in_ready_done", in_ready, 1'b0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_out_valid", out_valid, 1'b1);
         check("hold_value", sacred_value, exp_val);
         check("hold_overflow", overflow, exp_ovf);
         check("hold_in_ready", in_ready, 1'b0);
      end
      // take the result with a new request already pending: must not be accepted on this edge
      n_in = 32'd7; k_in = 8'd1; m_in = 8'd0; p_in = 8'd0; q_in = 8'd0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      check("out_valid_after_take", out_valid, 1'b0);
      check("in_ready_after_take", in_ready, 1'b1);
      check("busy_after_take", busy, 1'b0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      n_in = '0; k_in = '0; m_in = '0; p_in = '0; q_in = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_value", sacred_value, 64'd0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_busy", busy, 1'b0);

      // directed
      run_req(32'd5, 0, 0, 0, 0, 0);
      run_req(32'd2, 2, 0, 0, 0, 1);
      run_req(32'd3, -1, 0, 0, 0, 0);
      run_req(32'd1, 0, 0, 2, 0, 0);
      run_req(32'd1, 0, 1, 2, 0, 2);
      run_req(32'hFFFF_FFFF, 10, 0, 0, 0, 0);
      run_req(32'hFFFF_FFFF, 11, 0, 0, 0, 0);
      run_req(32'hFFFF_FFFF, 11, 3, -2, 1, 0);
      run_req(32'd0, 3, -2, 1, 4, 0);
      run_req(32'd1, -3, 0, 0, 0, 0);
      run_req(32'h1234_5678, -128, 0, 0, 0, 0);
      run_req(32'd9, 0, 0, 0, -128, 0);
      run_req(32'h0000_BEEF, 1, -1, 1, -1, 10);

      // reset during WAIT of a k=5 request
      @(negedge clk);
      n_in = 32'd4; k_in = 8'd5; m_in = 8'd0; p_in = 8'd0; q_in = 8'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_value", sacred_value, 64'd0);
      check("abort_busy", busy, 1'b0);
      check("abort_overflow", overflow, 1'b0);

      // randomized
      for (int r = 0; r < 40; r++) begin
         logic [31:0] rn;
         rn = (r % 3 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
         run_req(rn, int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4,
                 int'($urandom_range(0, 8)) - 4, int'($urandom_range(0, 8)) - 4,
                 int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
